// File: rtl/sdram_scanout_pkg.sv
// Shared types and defaults for the sdram_scanout streaming read master.
package sdram_scanout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_DRAIN
  } scan_state_t;

  localparam int XWIDTH_DEF  = 20;
  localparam int COLBITS_DEF = 8;
  localparam int LENW        = 5;  // holds a burst length of 1..16
  localparam int RDLENW      = 4;  // words-1 as sent to the controller

  function automatic int unsigned min3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sdram_scanout_if.sv
// Controller read port plus consumer stream of sdram_scanout; master is the scanout side.
interface sdram_scanout_if
  import sdram_scanout_pkg::*;
#(
    parameter int XWIDTH = XWIDTH_DEF,
    parameter int DWIDTH = 16
) ();

    logic [XWIDTH-1:0] rd_addr;
    logic [RDLENW-1:0] rd_len;
    logic              rd_req;
    logic              rd_ack;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_rdy;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rd_addr, rd_len, rd_req,
        input  rd_ack, rd_data, rd_rdy,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_addr, rd_len, rd_req,
        output rd_ack, rd_data, rd_rdy,
        input  out_data, out_valid,
        output out_ready
    );

endinterface

// File: rtl/sdram_scanout_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head reads as zero while empty.
module sdram_scanout_fifo #(
    parameter int DEPTH  = 32,
    parameter int DWIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic              valid,
    output logic [AW:0]       count
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;

    assign valid  = (count != '0);
    assign pop_ok = pop && valid;
    assign dout   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop_ok && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/sdram_scanout.sv
// Credit-limited burst read master feeding a FIFO for a streaming consumer.
// Optional SDRAM_SCANOUT_LOOP_EN: restart from base_addr after each pass until stop.
module sdram_scanout
  import sdram_scanout_pkg::*;
#(
    parameter int XWIDTH     = XWIDTH_DEF,
    parameter int COLBITS    = COLBITS_DEF,
    parameter int DWIDTH     = 16,
    parameter int BURST      = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int CNTBITS    = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [XWIDTH-1:0]  base_addr,
    input  logic [CNTBITS-1:0] word_count,
    output logic               busy,
    output logic               done,
    sdram_scanout_if.master    bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    scan_state_t        state, state_d;
    logic [XWIDTH-1:0]  addr;
    logic [CNTBITS-1:0] remaining;
`ifdef SDRAM_SCANOUT_LOOP_EN
    logic [XWIDTH-1:0]  base_l;
    logic [CNTBITS-1:0] count_l;
`endif
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      credits;
    logic [CW-1:0]      inc;
    logic               stop_seen;
    logic               rd_req_q;
    logic [XWIDTH-1:0]  rd_addr_q;
    logic [RDLENW-1:0]  rd_len_q;
    logic [LENW-1:0]    burst_len;
    logic [LENW-1:0]    acc_len;
    int unsigned        col_room;
    logic               credit_ok;
    logic               push;
    logic               do_load, do_zero, do_issue, do_accept, do_reload, do_finish;

    assign bus.rd_req  = rd_req_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_len  = rd_len_q;

    // Words arriving with nothing outstanding belong to a request lost to reset
    assign push = bus.rd_rdy && (inflight != '0);

    // Credits use registered occupancy: a pop this cycle frees space only next cycle
    assign credits   = CW'(FIFO_DEPTH) - fifo_count - inflight;
    assign col_room  = (32'd1 << COLBITS) - 32'(addr[COLBITS-1:0]);
    assign burst_len = LENW'(min3(32'(BURST), 32'(remaining), col_room));
    assign credit_ok = 32'(credits) >= 32'(burst_len);
    assign acc_len   = LENW'(rd_len_q) + LENW'(1);
    assign inc       = do_accept ? CW'(acc_len) : '0;

    always_comb begin
        state_d   = state;
        do_load   = 1'b0;
        do_zero   = 1'b0;
        do_issue  = 1'b0;
        do_accept = 1'b0;
        do_reload = 1'b0;
        do_finish = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        do_zero = 1'b1;
                    end else begin
                        do_load = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (stop || stop_seen) begin
                    state_d = ST_DRAIN;
                end else if (remaining == '0) begin
`ifdef SDRAM_SCANOUT_LOOP_EN
                    do_reload = 1'b1;
`else
                    state_d = ST_DRAIN;
`endif
                end else if (credit_ok) begin
                    do_issue = 1'b1;
                    state_d  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.rd_ack) begin
                    do_accept = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    do_finish = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            stop_seen <= 1'b0;
            inflight  <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
        end else begin
            state    <= state_d;
            done     <= do_zero || do_finish;
            inflight <= inflight + inc - CW'(push);
            if (do_load)        busy <= 1'b1;
            else if (do_finish) busy <= 1'b0;
            if (do_load)
                stop_seen <= 1'b0;
            else if (stop && (state == ST_REQ || state == ST_WAIT_ACK))
                stop_seen <= 1'b1;
            if (do_issue) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= addr;
                rd_len_q  <= RDLENW'(burst_len - LENW'(1));
            end else if (do_accept) begin
                rd_req_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_load) begin
            addr      <= base_addr;
            remaining <= word_count;
        end else if (do_accept) begin
            addr      <= addr + XWIDTH'(acc_len);
            remaining <= remaining - CNTBITS'(acc_len);
        end
`ifdef SDRAM_SCANOUT_LOOP_EN
        else if (do_reload) begin
            addr      <= base_l;
            remaining <= count_l;
        end
`endif
    end

`ifdef SDRAM_SCANOUT_LOOP_EN
    always_ff @(posedge clk) begin
        if (do_load) begin
            base_l  <= base_addr;
            count_l <= word_count;
        end
    end
`endif

    sdram_scanout_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (bus.rd_data),
        .pop     (bus.out_ready),
        .dout    (bus.out_data),
        .valid   (bus.out_valid),
        .count   (fifo_count)
    );

    a_rdy_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.rd_rdy && inflight == '0))
        else $warning("sdram_scanout: rd_rdy with no outstanding request dropped");

endmodule

// File: tb/tb_sdram_scanout.sv
// Bench for sdram_scanout: controller/consumer models plus a burst-plan reference model.
module tb_sdram_scanout;

    localparam int XW = 20, DW = 16, CB = 8, BURST = 8, DEPTH = 32, CNTB = 20;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [XW-1:0]   base_addr = '0;
    logic [CNTB-1:0] word_count = '0;
    logic            busy, done;

    sdram_scanout_if #(.XWIDTH(XW), .DWIDTH(DW)) bus ();

    sdram_scanout #(
        .XWIDTH(XW), .COLBITS(CB), .DWIDTH(DW), .BURST(BURST),
        .FIFO_DEPTH(DEPTH), .CNTBITS(CNTB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [XW-1:0] addr; logic [3:0] len; } req_t;
    typedef struct { logic [XW-1:0] addr; int due; } word_t;
    typedef struct {
        logic [XW-1:0] base; int cnt; int pct; int nreq;
        logic [XW-1:0] a0; logic [3:0] l0; logic [XW-1:0] al; logic [3:0] ll;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, delivered = 0;
    int ctl_st = 0, ack_wait = 0, force_delay = 0, ready_pct = 0;
    bit lat_en = 1'b1, lat_armed = 1'b0;
    req_t          seen_q[$];
    req_t          exp_req_q[$];
    word_t         pend_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_word_q[$];

    function automatic logic [DW-1:0] word_of(logic [XW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'hA5C};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference plan: split the range into bursts limited by BURST, remaining and column room
    task automatic build_exp(input logic [XW-1:0] base, input int cnt);
        int unsigned a, rem, len, room;
        exp_req_q.delete();
        exp_word_q.delete();
        a   = base;
        rem = cnt;
        while (rem > 0) begin
            room = (1 << CB) - (a % (1 << CB));
            len  = BURST;
            if (rem < len)  len = rem;
            if (room < len) len = room;
            exp_req_q.push_back('{XW'(a), 4'(len - 1)});
            for (int i = 0; i < int'(len); i++) exp_word_q.push_back(word_of(XW'(a + i)));
            a   = (a + len) % (1 << XW);
            rem = rem - len;
        end
    endtask

    // Controller, consumer and monitors share one negedge process to keep ordering fixed
    initial begin : model
        bus.rd_ack = 1'b0; bus.rd_rdy = 1'b0; bus.rd_data = '0; bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.rd_ack = 1'b0;
            bus.rd_rdy = 1'b0;
            if (done) done_cnt++;
            if (lat_armed) begin
                chk("latency out_valid", bus.out_valid, 1);
                lat_armed = 1'b0;
            end
            if (ctl_st == 2) begin
                chk("rd_req drops after ack", bus.rd_req, 0);
                ctl_st = 0;
            end else if (ctl_st == 1) begin
                chk("request held", {bus.rd_req, bus.rd_addr, bus.rd_len},
                    {1'b1, seen_q[$].addr, seen_q[$].len});
                if (ack_wait > 0) ack_wait--;
            end
            if (ctl_st == 0 && bus.rd_req) begin
                seen_q.push_back('{bus.rd_addr, bus.rd_len});
                ack_wait = (force_delay != 0 ? force_delay : $urandom_range(1, 3)) - 1;
                ctl_st = 1;
            end
            if (ctl_st == 1 && ack_wait == 0) begin
                bus.rd_ack = 1'b1;
                for (int i = 0; i <= int'(bus.rd_len); i++)
                    pend_q.push_back('{XW'(bus.rd_addr + i), cyc + 3});
                ctl_st = 2;
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(0, 3) != 0) begin
                bus.rd_rdy  = 1'b1;
                bus.rd_data = word_of(pend_q[0].addr);
                void'(pend_q.pop_front());
                delivered++;
                if (lat_en && !bus.out_valid) lat_armed = 1'b1;
            end
            bus.out_ready = ($urandom_range(1, 100) <= ready_pct);
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        end
    end

    task automatic compare_run(input string tag);
        int n;
        chk({tag, " request count"}, seen_q.size(), exp_req_q.size());
        n = (seen_q.size() < exp_req_q.size()) ? seen_q.size() : exp_req_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " request"}, {seen_q[i].addr, seen_q[i].len},
                {exp_req_q[i].addr, exp_req_q[i].len});
            chk({tag, " column boundary"},
                (int'(seen_q[i].addr[CB-1:0]) + int'(seen_q[i].len) + 1) <= (1 << CB), 1);
        end
        chk({tag, " word count"}, got_q.size(), exp_word_q.size());
        n = (got_q.size() < exp_word_q.size()) ? got_q.size() : exp_word_q.size();
        for (int i = 0; i < n; i++) chk({tag, " word"}, got_q[i], exp_word_q[i]);
    endtask

    task automatic wait_finish(input string tag, input int cnt);
        int t;
        t = 0;
        while ((done_cnt == 0 || got_q.size() < cnt) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " completes in budget"}, t < 4000, 1);
        repeat (5) @(negedge clk);
        chk({tag, " one done pulse"}, done_cnt, 1);
        chk({tag, " idle after done"}, {busy, bus.rd_req}, 0);
    endtask

    task automatic run_case(input string tag, input logic [XW-1:0] base, input int cnt, input int pct);
        seen_q.delete(); got_q.delete();
        done_cnt = 0; ready_pct = pct;
        build_exp(base, cnt);
        base_addr = base; word_count = CNTB'(cnt); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy after start"}, busy, 1);
        wait_finish(tag, cnt);
        compare_run(tag);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[5];
        int   t, n_seen;
        tbl[0] = '{20'h00010, 20, 100, 3, 20'h00010, 4'd7, 20'h00020, 4'd3};
        tbl[1] = '{20'h000FC,  8,  70, 2, 20'h000FC, 4'd3, 20'h00100, 4'd3};
        tbl[2] = '{20'h00005,  1, 100, 1, 20'h00005, 4'd0, 20'h00005, 4'd0};
        tbl[3] = '{20'hFFFFE,  4,  50, 2, 20'hFFFFE, 4'd1, 20'h00000, 4'd1};
        tbl[4] = '{20'h00000, 16,  40, 2, 20'h00000, 4'd7, 20'h00008, 4'd7};

        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, done, bus.rd_req, bus.rd_addr, bus.rd_len,
                              bus.out_valid, bus.out_data}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_case($sformatf("vec%0d", i), tbl[i].base, tbl[i].cnt, tbl[i].pct);
            chk("vec request total", seen_q.size(), tbl[i].nreq);
            if (seen_q.size() > 0) begin
                chk("vec first request", {seen_q[0].addr, seen_q[0].len}, {tbl[i].a0, tbl[i].l0});
                chk("vec last request", {seen_q[$].addr, seen_q[$].len}, {tbl[i].al, tbl[i].ll});
            end
        end

        // Zero-length start: immediate done, never busy, no request
        seen_q.delete(); done_cnt = 0;
        base_addr = 20'h00123; word_count = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero count done", {done, busy}, 2'b10);
        @(negedge clk);
        chk("zero count done one cycle", {done, busy}, 2'b00);
        repeat (10) @(negedge clk);
        chk("zero count no request", seen_q.size(), 0);
        chk("zero count done pulses", done_cnt, 1);

        // Back-pressure: no pops, credits cap outstanding words at the FIFO depth
        seen_q.delete(); got_q.delete(); done_cnt = 0; delivered = 0; ready_pct = 0;
        build_exp(20'h00000, 64);
        base_addr = '0; word_count = CNTB'(64); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (delivered < DEPTH && t < 2000) begin @(negedge clk); t++; end
        chk("backpressure fill in budget", t < 2000, 1);
        repeat (40) @(negedge clk);
        chk("backpressure request count", seen_q.size(), 4);
        chk("backpressure no new request", bus.rd_req, 0);
        chk("backpressure fifo holds", {bus.out_valid, 6'(got_q.size())}, {1'b1, 6'd0});
        ready_pct = 100;
        wait_finish("backpressure", 64);
        compare_run("backpressure");

        // Stop while a request waits for ack: that burst completes, nothing more issued
        seen_q.delete(); got_q.delete(); done_cnt = 0; ready_pct = 100; force_delay = 3;
        base_addr = 20'h00040; word_count = CNTB'(64); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!bus.rd_req && t < 100) begin @(negedge clk); t++; end
        chk("stop request seen", bus.rd_req, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop request held", bus.rd_req, 1);
        wait_finish("stop", 8);
        force_delay = 0;
        chk("stop request count", seen_q.size(), 1);
        if (seen_q.size() > 0)
            chk("stop request", {seen_q[0].addr, seen_q[0].len}, {20'h00040, 4'd7});
        chk("stop word count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk("stop word", got_q[i], word_of(XW'(20'h00040 + i)));

        // Asynchronous reset mid-burst; late returning words must be dropped
        seen_q.delete(); got_q.delete(); done_cnt = 0; delivered = 0; ready_pct = 0;
        base_addr = 20'h00200; word_count = CNTB'(32); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(delivered >= 3 && pend_q.size() > 0) && t < 500) begin @(negedge clk); t++; end
        chk("reset setup in budget", t < 500, 1);
        #2;
        lat_en = 1'b0; lat_armed = 1'b0; ctl_st = 0;
        n_seen = seen_q.size();
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", {busy, done, bus.rd_req, bus.rd_addr, bus.rd_len,
                                    bus.out_valid, bus.out_data}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        while (pend_q.size() > 0 && t < 200) begin @(negedge clk); t++; end
        chk("late words drained in budget", t < 200, 1);
        ready_pct = 100;
        repeat (10) @(negedge clk);
        chk("late words dropped", {bus.out_valid, 8'(got_q.size())}, 0);
        chk("after reset idle", {busy, bus.rd_req, 8'(seen_q.size() - n_seen)}, 0);
        chk("after reset no done", done_cnt, 0);
        lat_en = 1'b1;

        // Randomized ranges against the reference plan
        for (int i = 0; i < 6; i++) begin
            logic [XW-1:0] b;
            b = XW'($urandom);
            if (i < 2) b[CB-1:0] = 8'hF0 + 8'($urandom_range(0, 15));
            run_case($sformatf("rand%0d", i), b, $urandom_range(1, 70), $urandom_range(30, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
